gsens_tilt_calib: RTL

GSENS_TILT_CALIB -- requirements
Module: gsens_tilt_calib

---
 rtl/gsens_pkg.sv | 14 +
 rtl/gsens_axis_acc.sv | 92 +++++++++
 rtl/gsens_tilt_calib.sv | 106 ++++++++++
 3 files changed

// File: rtl/gsens_pkg.sv
// Shared types and widths for the tilt-calibration block.
package gsens_pkg;

    localparam int unsigned SAMPLE_W = 16;
    localparam int unsigned TILT_W   = 4;

    localparam logic [TILT_W-1:0] TILT_MAX = '1;

    typedef enum logic {
        StCalibrate,
        StRun
    } state_e;

endpackage

// File: rtl/gsens_axis_acc.sv
// One axis: sample accumulator, zero-offset latch and tilt magnitude/direction.
module gsens_axis_acc
    import gsens_pkg::*;
#(
    parameter int unsigned AVG_LOG2   = 3,
    parameter int unsigned CAL_LOG2   = 4,
    parameter int unsigned TILT_SHIFT = 4,
    parameter int unsigned DEADZONE   = 1
) (
    input  logic                clk,
    input  logic                resetN,
    input  logic                clear,
    input  logic                accept,
    input  logic                cal_done,
    input  logic                win_done,
    input  logic [SAMPLE_W-1:0] sample,
    output logic [TILT_W-1:0]   amount,
    output logic                direction
);

    // One accumulator serves both calibration and run windows.
    localparam int unsigned ACC_W = SAMPLE_W + ((CAL_LOG2 > AVG_LOG2) ? CAL_LOG2 : AVG_LOG2);

    logic signed [ACC_W-1:0]    acc_q, acc_d;
    logic signed [ACC_W-1:0]    sum, cal_shift, avg_shift;
    logic signed [SAMPLE_W-1:0] offset_q, offset_d, avg;
    logic signed [SAMPLE_W:0]   diff;
    logic [SAMPLE_W:0]          abs_diff, mag_full;
    logic [TILT_W-1:0]          mag_sat, amount_q, amount_d;
    logic                       dir_q, dir_d, in_deadzone;
    logic                       unused_shift;

    // Datapath: include the current sample so a window closes on its last strobe.
    always_comb begin
        sum       = acc_q + ACC_W'($signed(sample));
        cal_shift = sum >>> CAL_LOG2;
        avg_shift = sum >>> AVG_LOG2;
        avg       = avg_shift[SAMPLE_W-1:0];
        diff      = {avg[SAMPLE_W-1], avg} - {offset_q[SAMPLE_W-1], offset_q};
        abs_diff  = diff[SAMPLE_W] ? unsigned'(-diff) : unsigned'(diff);
        mag_full  = abs_diff >> TILT_SHIFT;
        mag_sat   = (mag_full > {{(SAMPLE_W + 1 - TILT_W){1'b0}}, TILT_MAX})
                    ? TILT_MAX : mag_full[TILT_W-1:0];
        in_deadzone = ({{(32 - TILT_W){1'b0}}, mag_sat} <= DEADZONE);
    end

    // Averages of 16-bit samples always fit back in 16 bits.
    assign unused_shift = ^{cal_shift[ACC_W-1:SAMPLE_W], avg_shift[ACC_W-1:SAMPLE_W]};

    // Next-state: clear wins, then offset latch, window close or plain accumulate.
    always_comb begin
        acc_d    = acc_q;
        offset_d = offset_q;
        amount_d = amount_q;
        dir_d    = dir_q;
        if (clear) begin
            acc_d    = '0;
            amount_d = '0;
            dir_d    = 1'b0;
        end else if (accept) begin
            if (cal_done) begin
                offset_d = cal_shift[SAMPLE_W-1:0];
                acc_d    = '0;
            end else if (win_done) begin
                acc_d    = '0;
                amount_d = in_deadzone ? '0 : mag_sat;
                dir_d    = in_deadzone ? 1'b0 : diff[SAMPLE_W];
            end else begin
                acc_d = sum;
            end
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            acc_q    <= '0;
            offset_q <= '0;
            amount_q <= '0;
            dir_q    <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            offset_q <= offset_d;
            amount_q <= amount_d;
            dir_q    <= dir_d;
        end
    end

    assign amount    = amount_q;
    assign direction = dir_q;

endmodule

// File: rtl/gsens_tilt_calib.sv
// Two-axis accelerometer tilt detector with self-captured zero offset.
module gsens_tilt_calib
    import gsens_pkg::*;
#(
    parameter int unsigned AVG_LOG2   = 3,
    parameter int unsigned CAL_LOG2   = 4,
    parameter int unsigned TILT_SHIFT = 4,
    parameter int unsigned DEADZONE   = 1
) (
    input  logic                clk,
    input  logic                resetN,
    input  logic                sample_valid,
    input  logic [SAMPLE_W-1:0] sample_x,
    input  logic [SAMPLE_W-1:0] sample_y,
    input  logic                calibrate,
    output logic [TILT_W-1:0]   tilt_amount_x,
    output logic [TILT_W-1:0]   tilt_amount_y,
    output logic                tilt_direction_x,
    output logic                tilt_direction_y,
    output logic                calibrated,
    output logic                tilt_valid
);

    localparam int unsigned CNT_W = ((CAL_LOG2 > AVG_LOG2) ? CAL_LOG2 : AVG_LOG2) + 1;
    localparam logic [CNT_W-1:0] CAL_LAST = CNT_W'((1 << CAL_LOG2) - 1);
    localparam logic [CNT_W-1:0] AVG_LAST = CNT_W'((1 << AVG_LOG2) - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             tilt_valid_q;
    logic             accept, last, cal_done, win_done;

    // Shared window control; a coincident calibrate discards the sample.
    always_comb begin
        accept   = sample_valid & ~calibrate;
        last     = (state_q == StCalibrate) ? (count_q == CAL_LAST) : (count_q == AVG_LAST);
        cal_done = accept & last & (state_q == StCalibrate);
        win_done = accept & last & (state_q == StRun);
    end

    // FSM next state and sample counter.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        if (calibrate) begin
            state_d = StCalibrate;
            count_d = '0;
        end else if (accept) begin
            count_d = last ? '0 : count_q + CNT_W'(1);
            if (cal_done) begin
                state_d = StRun;
            end
        end
    end

    // FSM, counter and tilt_valid registers.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q      <= StCalibrate;
            count_q      <= '0;
            tilt_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            tilt_valid_q <= win_done;
        end
    end

    assign calibrated = (state_q == StRun);
    assign tilt_valid = tilt_valid_q;

    gsens_axis_acc #(
        .AVG_LOG2   (AVG_LOG2),
        .CAL_LOG2   (CAL_LOG2),
        .TILT_SHIFT (TILT_SHIFT),
        .DEADZONE   (DEADZONE)
    ) u_axis_x (
        .clk       (clk),
        .resetN    (resetN),
        .clear     (calibrate),
        .accept    (accept),
        .cal_done  (cal_done),
        .win_done  (win_done),
        .sample    (sample_x),
        .amount    (tilt_amount_x),
        .direction (tilt_direction_x)
    );

    gsens_axis_acc #(
        .AVG_LOG2   (AVG_LOG2),
        .CAL_LOG2   (CAL_LOG2),
        .TILT_SHIFT (TILT_SHIFT),
        .DEADZONE   (DEADZONE)
    ) u_axis_y (
        .clk       (clk),
        .resetN    (resetN),
        .clear     (calibrate),
        .accept    (accept),
        .cal_done  (cal_done),
        .win_done  (win_done),
        .sample    (sample_y),
        .amount    (tilt_amount_y),
        .direction (tilt_direction_y)
    );

endmodule
